// File: rtl/mem_pkg.sv
// Shared constants and types for the M-stage load/store unit.
package mem_pkg;

  localparam int unsigned XLEN = 32;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // ResultSrc value selecting memory read data (i.e. a load)
  localparam logic [1:0] RES_MEM = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10,
    ST_HOLD = 2'b11
  } mau_state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// req/gnt/rvalid data-memory bus between the load/store unit and memory.
interface mem_access_unit_if;
  import mem_pkg::*;

  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: enables, store replication, load
// extraction/extension and misalignment detection.
module lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]      offs,
  input  logic [XLEN-1:0] wd,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata_ext,
  output logic            misalign
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata >> {offs, 3'b000};

  // Store side: lane enables, replicated data, legality of size/offset
  always_comb begin
    be       = 4'h0;
    wdata    = wd;
    misalign = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        be    = 4'b0001 << offs;
        wdata = {4{wd[7:0]}};
      end
      F3_H, F3_HU: begin
        be       = 4'b0011 << offs;
        wdata    = {2{wd[15:0]}};
        misalign = offs[0];
      end
      F3_W: begin
        be       = 4'hF;
        misalign = (offs != 2'b00);
      end
      default: misalign = 1'b1;
    endcase
  end

  // Load side: pick the addressed lane and sign/zero extend
  always_comb begin
    rdata_ext = shifted;
    case (funct3)
      F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   rdata_ext = {24'h0, shifted[7:0]};
      F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   rdata_ext = {16'h0, shifted[15:0]};
      default: rdata_ext = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage load/store unit: issues one bus transaction per M access and
// stalls the pipeline until it completes (or times out).
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   ALUResult_m,
  input  logic [XLEN-1:0]   WriteData_m,
  input  logic [2:0]        funct3_m,
  input  logic              MemWrite_m,
  input  logic [1:0]        ResultSrc_m,
  input  logic              adv_m,
  input  logic              flush_m,
  mem_access_unit_if.master dmem,
  output logic [XLEN-1:0]   ReadData_m,
  output logic              stall_m,
  output logic              misalign_m,
  output logic              bus_err_m
);

  localparam int unsigned    CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mau_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] hold_q, hold_d;

  logic            access, is_store, legal;
  logic            misal_w;
  logic [3:0]      be_w;
  logic [XLEN-1:0] wdata_w, ext_w;
  logic            req, done, err, stall, tmo;
  logic [XLEN-1:0] rd;

  assign is_store = MemWrite_m;
  assign access   = MemWrite_m | (ResultSrc_m == RES_MEM);
  assign legal    = access & ~misal_w;
  assign tmo      = (cnt_q == CNT_LAST);

  lsu_align u_align (
    .offs      (ALUResult_m[1:0]),
    .wd        (WriteData_m),
    .funct3    (funct3_m),
    .rdata     (dmem.rdata),
    .be        (be_w),
    .wdata     (wdata_w),
    .rdata_ext (ext_w),
    .misalign  (misal_w)
  );

  // State, timeout counter and load-data hold register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  // Next state, request/completion decode and pipeline-facing results
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    req     = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    rd      = '0;
    case (state_q)
      ST_IDLE: begin
        if (legal) begin
          req = 1'b1;
          if (dmem.gnt) begin
            if (is_store) begin
              done   = 1'b1;
              hold_d = '0;
            end else begin
              state_d = ST_RESP;
              cnt_d   = '0;
            end
          end else begin
            state_d = ST_REQ;
            cnt_d   = '0;
          end
        end
      end
      ST_REQ: begin
        req = 1'b1;
        if (dmem.gnt) begin
          if (is_store) begin
            done   = 1'b1;
            hold_d = '0;
          end else begin
            state_d = ST_RESP;
            cnt_d   = '0;
          end
        end else if (tmo) begin
          done   = 1'b1;
          err    = 1'b1;
          hold_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (dmem.rvalid) begin
          done   = 1'b1;
          rd     = ext_w;
          hold_d = ext_w;
        end else if (tmo) begin
          done   = 1'b1;
          err    = 1'b1;
          hold_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        rd = hold_q;
        if (adv_m || flush_m) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (done) state_d = adv_m ? ST_IDLE : ST_HOLD;

    stall = legal & (state_q != ST_HOLD) & ~done;

    // Nothing leaks out while reset is held, regardless of pipeline inputs
    if (rst) begin
      req   = 1'b0;
      err   = 1'b0;
      rd    = '0;
      stall = 1'b0;
    end
  end

  assign dmem.req   = req;
  assign dmem.we    = req & MemWrite_m;
  assign dmem.addr  = req ? {ALUResult_m[XLEN-1:2], 2'b00} : '0;
  assign dmem.be    = req ? be_w : 4'h0;
  assign dmem.wdata = req ? wdata_w : '0;

  assign ReadData_m = rd;
  assign stall_m    = stall;
  assign bus_err_m  = err;
  assign misalign_m = access & misal_w & ~rst;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResult_m, WriteData_m;
  logic [2:0]  funct3_m;
  logic        MemWrite_m;
  logic [1:0]  ResultSrc_m;
  logic        adv_m, flush_m;
  logic [31:0] ReadData_m;
  logic        stall_m, misalign_m, bus_err_m;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_unit_if dmem ();

  mem_access_unit #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .ALUResult_m (ALUResult_m),
    .WriteData_m (WriteData_m),
    .funct3_m    (funct3_m),
    .MemWrite_m  (MemWrite_m),
    .ResultSrc_m (ResultSrc_m),
    .adv_m       (adv_m),
    .flush_m     (flush_m),
    .dmem        (dmem),
    .ReadData_m  (ReadData_m),
    .stall_m     (stall_m),
    .misalign_m  (misalign_m),
    .bus_err_m   (bus_err_m)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    ALUResult_m = '0; WriteData_m = '0; funct3_m = '0;
    MemWrite_m = 1'b0; ResultSrc_m = 2'b00; adv_m = 1'b0; flush_m = 1'b0;
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = '0;
  endtask

  task automatic set_acc(input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3, input logic st);
    ALUResult_m = a; WriteData_m = wd; funct3_m = f3;
    MemWrite_m = st; ResultSrc_m = st ? 2'b00 : RES_MEM;
  endtask

  task automatic do_store(input string tag, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f3, input int gnt_dly,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input logic [31:0] exp_addr);
    int stalls = 0;
    for (int i = 0; i <= gnt_dly; i++) begin
      @(negedge clk);
      set_acc(a, wd, f3, 1'b1);
      dmem.gnt = (i == gnt_dly);
      adv_m    = (i == gnt_dly);
      #1;
      check({tag, " req"}, 32'(dmem.req), 32'd1);
      if (stall_m) stalls++;
      if (i == 0) begin
        check({tag, " we"}, 32'(dmem.we), 32'd1);
        check({tag, " be"}, 32'(dmem.be), 32'(exp_be));
        check({tag, " wdata"}, dmem.wdata, exp_wd);
        check({tag, " addr"}, dmem.addr, exp_addr);
      end
    end
    check({tag, " stall cycles"}, 32'(stalls), 32'(gnt_dly));
    @(negedge clk);
    idle_in();
    #1;
    check({tag, " req after"}, 32'(dmem.req), 32'd0);
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] rdat, input int gnt_dly, input int rv_dly,
                         input logic adv_end, input logic [31:0] exp_data);
    int stalls = 0;
    for (int i = 0; i <= gnt_dly; i++) begin
      @(negedge clk);
      set_acc(a, 32'h0, f3, 1'b0);
      dmem.gnt = (i == gnt_dly);
      dmem.rvalid = 1'b0;
      adv_m = 1'b0;
      #1;
      check({tag, " req"}, 32'(dmem.req), 32'd1);
      if (i == 0) check({tag, " we"}, 32'(dmem.we), 32'd0);
      if (stall_m) stalls++;
    end
    for (int j = 1; j <= rv_dly; j++) begin
      @(negedge clk);
      dmem.gnt    = 1'b0;
      dmem.rvalid = (j == rv_dly);
      dmem.rdata  = (j == rv_dly) ? rdat : 32'hA5A5A5A5;
      adv_m       = (j == rv_dly) & adv_end;
      #1;
      check({tag, " req in resp"}, 32'(dmem.req), 32'd0);
      if (stall_m) stalls++;
      if (j == rv_dly) check({tag, " data"}, ReadData_m, exp_data);
    end
    check({tag, " stall cycles"}, 32'(stalls), 32'(gnt_dly + rv_dly));
  endtask

  task automatic chk_misal(input string tag, input logic [31:0] a, input logic [2:0] f3,
                           input logic st);
    @(negedge clk);
    set_acc(a, 32'hFFFFFFFF, f3, st);
    dmem.gnt = 1'b1; dmem.rvalid = 1'b1; dmem.rdata = 32'h87654321; adv_m = 1'b1;
    #1;
    check({tag, " misalign"}, 32'(misalign_m), 32'd1);
    check({tag, " req"}, 32'(dmem.req), 32'd0);
    check({tag, " stall"}, 32'(stall_m), 32'd0);
    check({tag, " data"}, ReadData_m, 32'h0);
    @(negedge clk);
    idle_in();
  endtask

  // Prove the FSM is in IDLE: only IDLE grants a store in its first cycle
  task automatic chk_idle(input string tag);
    @(negedge clk);
    set_acc(32'h0000_0600, 32'h0, F3_W, 1'b1);
    dmem.gnt = 1'b1; adv_m = 1'b1;
    #1;
    check({tag, " idle req"}, 32'(dmem.req), 32'd1);
    check({tag, " idle stall"}, 32'(stall_m), 32'd0);
    @(negedge clk);
    idle_in();
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    set_acc(32'h0000_0100, 32'h0, F3_W, 1'b0);
    dmem.gnt = 1'b1;
    #1;
    check("reset req", 32'(dmem.req), 32'd0);
    check("reset stall", 32'(stall_m), 32'd0);
    check("reset data", ReadData_m, 32'h0);
    check("reset err", 32'(bus_err_m), 32'd0);
    check("reset be", 32'(dmem.be), 32'd0);
    @(negedge clk);
    idle_in();
    rst = 1'b0;

    do_store("sw", 32'h100, 32'hDEADBEEF, F3_W, 0, 4'hF, 32'hDEADBEEF, 32'h100);
    do_store("sb", 32'h103, 32'h12345678, F3_B, 2, 4'h8, 32'h78787878, 32'h100);
    do_store("sh", 32'h202, 32'h0000ABCD, F3_H, 1, 4'hC, 32'hABCDABCD, 32'h200);

    do_load("lb",  32'h102, F3_B,  32'h0080FF00, 0, 3, 1'b1, 32'hFFFFFF80);
    do_load("lbu", 32'h102, F3_BU, 32'h0080FF00, 0, 3, 1'b1, 32'h00000080);
    do_load("lh",  32'h202, F3_H,  32'h80011234, 1, 1, 1'b1, 32'hFFFF8001);
    do_load("lhu", 32'h202, F3_HU, 32'h80011234, 0, 1, 1'b1, 32'h00008001);

    chk_misal("lw@102", 32'h102, F3_W, 1'b0);
    chk_misal("lh@101", 32'h101, F3_H, 1'b0);
    chk_misal("sw@102", 32'h102, F3_W, 1'b1);
    chk_misal("f3=011", 32'h100, 3'b011, 1'b0);

    // Completion without adv: data held, no second request
    do_load("lw_hold", 32'h200, F3_W, 32'hCAFEF00D, 0, 1, 1'b0, 32'hCAFEF00D);
    @(negedge clk);
    dmem.rvalid = 1'b0; dmem.rdata = 32'h11111111; dmem.gnt = 1'b1; adv_m = 1'b0;
    #1;
    check("hold data", ReadData_m, 32'hCAFEF00D);
    check("hold req", 32'(dmem.req), 32'd0);
    check("hold stall", 32'(stall_m), 32'd0);
    @(negedge clk);
    dmem.rvalid = 1'b1; adv_m = 1'b1;
    #1;
    check("hold data2", ReadData_m, 32'hCAFEF00D);
    check("hold req2", 32'(dmem.req), 32'd0);
    @(negedge clk);
    idle_in();
    #1;
    check("post-hold data", ReadData_m, 32'h0);
    chk_idle("post-hold");

    // Store never granted: 1 IDLE cycle then 16 REQ cycles, error on the last
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      set_acc(32'h300, 32'h55AA55AA, F3_W, 1'b1);
      dmem.gnt = 1'b0;
      adv_m = (k == 16);
      #1;
      if (k == 15) check("st tmo err early", 32'(bus_err_m), 32'd0);
      if (k == 15) check("st tmo stall early", 32'(stall_m), 32'd1);
      if (k == 16) check("st tmo err", 32'(bus_err_m), 32'd1);
      if (k == 16) check("st tmo stall", 32'(stall_m), 32'd0);
    end
    @(negedge clk);
    idle_in();
    #1;
    check("st tmo err clear", 32'(bus_err_m), 32'd0);
    check("st tmo req clear", 32'(dmem.req), 32'd0);

    // Load granted but no rvalid: 16 RESP cycles, error with zero data, then HOLD
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      set_acc(32'h400, 32'h0, F3_W, 1'b0);
      dmem.gnt = (k == 0);
      dmem.rvalid = 1'b0;
      dmem.rdata = 32'hFFFFFFFF;
      adv_m = 1'b0;
      #1;
      if (k == 15) check("ld tmo err early", 32'(bus_err_m), 32'd0);
      if (k == 16) begin
        check("ld tmo err", 32'(bus_err_m), 32'd1);
        check("ld tmo data", ReadData_m, 32'h0);
        check("ld tmo stall", 32'(stall_m), 32'd0);
      end
    end
    @(negedge clk);
    dmem.rvalid = 1'b1; dmem.rdata = 32'h12345678; flush_m = 1'b1;
    #1;
    check("late rvalid data", ReadData_m, 32'h0);
    check("late rvalid err", 32'(bus_err_m), 32'd0);
    check("late rvalid req", 32'(dmem.req), 32'd0);
    @(negedge clk);
    idle_in();
    chk_idle("post-flush");

    // Reset while waiting for read data
    @(negedge clk);
    set_acc(32'h500, 32'h0, F3_W, 1'b0);
    dmem.gnt = 1'b1;
    #1;
    check("rst-resp req0", 32'(dmem.req), 32'd1);
    @(negedge clk);
    dmem.gnt = 1'b0;
    #1;
    check("rst-resp in resp", 32'(dmem.req), 32'd0);
    check("rst-resp stall", 32'(stall_m), 32'd1);
    rst = 1'b1;
    #1;
    check("rst-resp req", 32'(dmem.req), 32'd0);
    check("rst-resp stall off", 32'(stall_m), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_in();
    chk_idle("post-rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
